// File: rtl/hls_deadlock_monitor_param.sv
// ---------------------------------------------------------------------------
// hls_deadlock_monitor_param
//
// Per-process deadlock monitor for the HLS dataflow top. It combines the
// masked axis stall and instance block indications into a raw block
// condition. An optional gate suppresses that condition while every
// masked-in instance is idle. The monitor then tracks how many consecutive
// cycles the condition has held. Once the threshold is reached it raises a
// sticky deadlock flag, which software clears with a one-cycle pulse. It
// also records the lowest-index channel that was contributing when the
// blocking episode began.
//
// Ports
//   clock            in   system clock
//   reset            in   synchronous, active-high reset
//   axis_block_sigs  in   [N_AXIS] per-channel axis stall indications
//   inst_idle_sigs   in   [N_INST] per-instance idle
//   inst_block_sigs  in   [N_INST] per-instance block
//   clear            in   single-cycle clear of sticky state
//   block            out  registered raw block (legacy-compatible)
//   deadlock         out  sticky deadlock flag
//   culprit_idx      out  [IDX_W] lowest contributing channel at block onset
//   culprit_valid    out  culprit_idx is meaningful
//   block_cycles     out  [CNT_W] current consecutive-block count
// ---------------------------------------------------------------------------
module hls_deadlock_monitor_param #(
    parameter int                N_AXIS    = 6,
    parameter int                N_INST    = 10,
    parameter logic [N_AXIS-1:0] AXIS_MASK = 6'b111100,
    parameter logic [N_INST-1:0] INST_MASK = 10'b0,
    parameter bit                IDLE_GATE = 1'b1,
    parameter int                THRESH    = 16,
    parameter int                CNT_W     = 8,
    parameter int                IDX_W     = (N_AXIS + N_INST > 1) ? $clog2(N_AXIS + N_INST) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_AXIS-1:0] axis_block_sigs,
    input  logic [N_INST-1:0] inst_idle_sigs,
    input  logic [N_INST-1:0] inst_block_sigs,
    input  logic              clear,
    output logic              block,
    output logic              deadlock,
    output logic [IDX_W-1:0]  culprit_idx,
    output logic              culprit_valid,
    output logic [CNT_W-1:0]  block_cycles
);

    localparam int               N_TOT     = N_AXIS + N_INST;
    localparam logic [CNT_W-1:0] THRESH_C  = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(THRESH - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BLOCKED  = 2'd1,
        DEADLOCK = 2'd2
    } state_t;

    state_t             state_q;
    logic               block_q;
    logic               deadlock_q;
    logic [IDX_W-1:0]   culprit_idx_q;
    logic               culprit_valid_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [N_TOT-1:0]   vec_d;
    logic               all_idle_d;
    logic               raw_d;
    logic [IDX_W-1:0]   culprit_d;

    // Axis channels occupy the low indices, instances the high ones, so a
    // culprit index >= N_AXIS names instance (idx - N_AXIS).
    assign vec_d = {inst_block_sigs & INST_MASK, axis_block_sigs & AXIS_MASK};

    // Masked-out instances count as idle. With no instance masked in there
    // is nothing to judge idleness on, so the gate is disabled.
    assign all_idle_d = (INST_MASK != '0) && (&(inst_idle_sigs | ~INST_MASK));

    assign raw_d = (|vec_d) && !(IDLE_GATE && all_idle_d);

    // Priority encoder: scanning downward leaves the lowest set index.
    always_comb begin
        culprit_d = '0;
        for (int i = N_TOT - 1; i >= 0; i--) begin
            if (vec_d[i]) begin
                culprit_d = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            block_q         <= 1'b0;
            deadlock_q      <= 1'b0;
            culprit_idx_q   <= '0;
            culprit_valid_q <= 1'b0;
            cnt_q           <= '0;
        end else begin
            // The legacy block output tracks raw regardless of clear/FSM.
            block_q <= raw_d;
            if (clear) begin
                // raw is ignored this cycle; re-detection starts next edge.
                state_q         <= IDLE;
                deadlock_q      <= 1'b0;
                culprit_idx_q   <= '0;
                culprit_valid_q <= 1'b0;
                cnt_q           <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (raw_d) begin
                            culprit_idx_q   <= culprit_d;
                            culprit_valid_q <= 1'b1;
                            cnt_q           <= CNT_W'(1);
                            if (THRESH == 1) begin
                                state_q    <= DEADLOCK;
                                deadlock_q <= 1'b1;
                            end else begin
                                state_q <= BLOCKED;
                            end
                        end else begin
                            cnt_q <= '0;
                        end
                    end
                    BLOCKED: begin
                        if (!raw_d) begin
                            // culprit_idx keeps its last value for debug.
                            state_q         <= IDLE;
                            cnt_q           <= '0;
                            culprit_valid_q <= 1'b0;
                        end else if (cnt_q == THRESH_M1) begin
                            state_q    <= DEADLOCK;
                            deadlock_q <= 1'b1;
                            cnt_q      <= THRESH_C;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    DEADLOCK: begin
                        // Sticky: everything frozen until clear or reset.
                        state_q <= DEADLOCK;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign block         = block_q;
    assign deadlock      = deadlock_q;
    assign culprit_idx   = culprit_idx_q;
    assign culprit_valid = culprit_valid_q;
    assign block_cycles  = cnt_q;

endmodule

// File: doc/hls_deadlock_monitor_param.md
Name: hls_deadlock_monitor_param

Overview:
- Parametrised per-process deadlock monitor for the HLS dataflow top.
- Generalises the fixed single-flag monitor:
  - configurable channel counts and per-channel masks;
  - optional instance-block contribution and all-idle gating;
  - consecutive-cycle persistence threshold;
  - sticky deadlock flag with software clear;
  - first-culprit channel capture.
- One instance per monitored dataflow process. Outputs feed the top-level deadlock reporter.

Parameters:
- N_AXIS, 6, number of axis_block_sigs bits.
- N_INST, 10, number of inst_idle_sigs / inst_block_sigs bits.
- AXIS_MASK, 6'b111100, bit i=1 includes axis_block_sigs[i].
- INST_MASK, 10'b0, bit j=1 includes inst_block_sigs[j].
- IDLE_GATE, 1, 1 = raw block is forced 0 while all masked-in instances are idle.
- THRESH, 16, consecutive raw-block cycles required to declare deadlock; legal range 1..2^CNT_W-1.
- CNT_W, 8, width of the persistence counter.
- IDX_W, clog2(N_AXIS+N_INST), culprit index width.

Ports:
- clock  in  1  system clock
- reset  in  1  reset
- axis_block_sigs  in  N_AXIS  per-channel axis stall indications
- inst_idle_sigs  in  N_INST  per-instance idle
- inst_block_sigs  in  N_INST  per-instance block
- clear  in  1  single-cycle clear of sticky state
- block  out  1  registered raw block (legacy-compatible)
- deadlock  out  1  sticky deadlock flag
- culprit_idx  out  IDX_W  lowest-index contributing channel at block onset
- culprit_valid  out  1  culprit_idx is meaningful
- block_cycles  out  CNT_W  current consecutive-block count

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clock.
- Reset values: all outputs 0; FSM = IDLE.
- Combined vector V, width N_AXIS+N_INST:
  - low bits = axis_block_sigs & AXIS_MASK;
  - high bits = inst_block_sigs & INST_MASK.
- all_idle = &(inst_idle_sigs | ~INST_MASK), i.e. masked-out instances are treated as idle.
  - If INST_MASK==0, all_idle=0 and gating is disabled.
- raw = |V & ~(IDLE_GATE & all_idle). Combinational, never exported.
- block <= raw every cycle, 1-cycle latency, independent of FSM and clear. With the default masks it is identical to the legacy monitor.
- FSM states IDLE, BLOCKED, DEADLOCK. Evaluated each rising edge; reset has priority, then clear, then the transitions below.
  - IDLE, raw=0: stay; cnt=0.
  - IDLE, raw=1:
    - capture culprit_idx = lowest set index of V (gated V);
    - culprit_valid<=1; cnt<=1;
    - if THRESH==1, go to DEADLOCK and set deadlock<=1; else go to BLOCKED.
  - BLOCKED, raw=0: go to IDLE; cnt<=0; culprit_valid<=0; culprit_idx holds its last value.
  - BLOCKED, raw=1, cnt==THRESH-1: go to DEADLOCK; deadlock<=1; cnt<=THRESH.
  - BLOCKED, raw=1, otherwise: cnt<=cnt+1.
  - DEADLOCK: sticky regardless of raw; cnt, culprit_idx and culprit_valid are frozen.
- clear=1:
  - FSM<=IDLE; deadlock<=0; cnt<=0; culprit_valid<=0; culprit_idx<=0.
  - raw in that cycle is ignored. Re-detection starts on the next edge with raw=1.
- Timing consequences:
  - deadlock rises on the THRESH-th consecutive edge that samples raw=1.
  - Any single raw=0 gap restarts counting from 0.
- Culprit selection:
  - The lowest index wins on simultaneous assertion.
  - Later-asserting channels never overwrite the captured value while in BLOCKED or DEADLOCK.
- block_cycles = cnt. It never wraps, because the counter stops at THRESH.
- Reset asserted mid-BLOCKED or mid-DEADLOCK returns everything to reset values on that edge.

Test Plan:
- Reset, then default masks, axis_block_sigs=6'b000100 held high:
  - block=1 one cycle after first sample;
  - culprit_idx=2, culprit_valid=1;
  - block_cycles counts 1..15;
  - deadlock=1 after the 16th edge; block_cycles=16.
- Masked bit: axis_block_sigs=6'b000011 held 40 cycles → block=0, deadlock=0, culprit_valid=0 throughout.
- Gap restart: raw high 10 cycles, low 1 cycle, high 16 cycles → block_cycles returns to 0 at the gap; deadlock rises only at the 16th cycle of the second burst.
- Simultaneous and late culprits:
  - bits 5 and 3 asserted together → culprit_idx=3;
  - bit 2 asserted later while BLOCKED → culprit_idx stays 3.
- Sticky and clear:
  - after deadlock, drop raw → deadlock stays 1;
  - pulse clear with raw=1 → deadlock=0 and block_cycles=0 next cycle;
  - block_cycles=1 the cycle after that.
- Instance mode and gating: INST_MASK=10'b1, IDLE_GATE=1, THRESH=1:
  - inst_block_sigs[0]=1 with inst_idle_sigs[0]=1 → no deadlock;
  - inst_idle_sigs[0]=0 → deadlock=1 after 1 edge; culprit_idx=6 (N_AXIS+0).
